// File: rtl/mem_access_unit.sv
// Memory-stage access unit: runs each M-stage load/store as a req/ack
// transaction, stalls the pipeline until it completes, and forms the W-stage load result.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    input  logic        lbW,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stallMem,
    output logic [31:0] readdataW,
    output logic [31:0] loadresultW,
    output logic        memerr,
    output logic        fsm_state
);

    // Handshake: mem_req rises one cycle after an access is seen in IDLE and
    // holds mem_we/mem_addr/mem_wdata stable until the cycle mem_ack is high
    // (or the timeout fires); mem_ack outside WAIT is ignored.

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          ldq;
    logic [1:0]    addrq;
    logic [1:0]    addrW;
    logic          access;
    logic          timeout_hit;
    logic          start;
    logic          done_ack;
    logic [7:0]    lbyte;

    assign access      = memtoregM | memwriteM;
    assign timeout_hit = (state == S_WAIT) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
    assign start       = (state == S_IDLE) && access;
    assign done_ack    = (state == S_WAIT) && mem_ack;

    always_comb begin
        state_nxt = state;
        stallMem  = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    state_nxt = S_WAIT;
                    stallMem  = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = S_IDLE;
                end else begin
                    stallMem = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request-side latches and the WAIT-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ldq       <= 1'b0;
            addrq     <= 2'b00;
        end else if (start) begin
            cnt       <= '0;
            mem_we    <= memwriteM;
            mem_addr  <= {aluoutM[31:2], 2'b00};
            mem_wdata <= writedataM;
            ldq       <= memtoregM & ~memwriteM;
            addrq     <= aluoutM[1:0];
        end else if ((state == S_WAIT) && !mem_ack && !timeout_hit) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memerr <= 1'b0;
        end else if (timeout_hit) begin
            memerr <= 1'b1;
        end
    end

    // W-stage read word: only a completing load writes it; a timed-out load
    // delivers a recognisable poison value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdataW <= '0;
            addrW     <= 2'b00;
        end else if (ldq && done_ack) begin
            readdataW <= mem_rdata;
            addrW     <= addrq;
        end else if (ldq && timeout_hit) begin
            readdataW <= 32'hDEADBEEF;
            addrW     <= addrq;
        end
    end

    always_comb begin
        lbyte = readdataW[7:0];
        case (addrW)
            2'd0: lbyte = readdataW[7:0];
            2'd1: lbyte = readdataW[15:8];
            2'd2: lbyte = readdataW[23:16];
            2'd3: lbyte = readdataW[31:24];
            default: lbyte = readdataW[7:0];
        endcase
    end

    assign loadresultW = lbW ? {{24{lbyte[7]}}, lbyte} : readdataW;
    assign mem_req     = (state == S_WAIT);
    assign fsm_state   = state;

endmodule
